// File: rtl/moore_rr_scheduler.sv
// moore_rr_scheduler
//   Shares one 2-bit T-flip-flop Moore engine (state {A,B}) among NREQ
//   requesters. A round-robin winner's LEN-bit word is captured and fed
//   to the engine serially, LSB first, one bit per clock. When the last
//   bit has been applied, the final {A,B} and the owner's id are
//   reported with a one-cycle done pulse.
//
// Ports
//   clk_i       rising-edge clock
//   res_i       synchronous active-high reset
//   req_i       level request per requester, held until granted
//   word_i      requester i drives word_i[i*LEN +: LEN]
//   gnt_o       one-hot, one-cycle grant pulse
//   busy_o      high while a job occupies the engine (RUN or DONE)
//   done_o      one-cycle pulse when a job finishes
//   done_id_o   id of the finished job, held until the next done
//   final_ab_o  engine state {A,B} after the last bit, held until next done
module moore_rr_scheduler #(
  parameter  int NREQ = 4,
  parameter  int LEN  = 8,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = $clog2(LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 res_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*LEN-1:0]  word_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [IW-1:0]        done_id_o,
  output logic [1:0]           final_ab_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   id_q;
  logic [1:0]      ab_q;
  logic [CW-1:0]   cnt_q;
  logic [LEN-1:0]  shreg_q;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;
  logic            done_q;
  logic [IW-1:0]   done_id_q;
  logic [1:0]      final_ab_q;

  // Round-robin search starting at ptr_q. Scanning offsets from the far
  // end down lets the nearest requester overwrite farther ones, so the
  // last assignment is the winner without needing a loop break.
  logic          win_vld;
  logic [IW-1:0] win_id;
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req_i[(int'(ptr_q) + off) % NREQ]) begin
        win_vld = 1'b1;
        win_id  = IW'((int'(ptr_q) + off) % NREQ);
      end
    end
  end

  logic [IW-1:0] ptr_d;
  assign ptr_d = (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;

  // Engine next state from the T-flip-flop equations.
  logic x, ta, tb;
  logic [1:0] ab_d;
  always_comb begin
    x    = shreg_q[0];
    ta   = ~x & ab_q[0];
    tb   = (~x & ~ab_q[0]) | (~x & ab_q[1]) | (x & ~ab_q[1] & ab_q[0]);
    ab_d = {ab_q[1] ^ ta, ab_q[0] ^ tb};
  end

  logic [CW-1:0] cnt_d;
  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      ab_q       <= 2'b00;
      cnt_q      <= '0;
      shreg_q    <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      final_ab_q <= 2'b00;
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        // DONE grants exactly like IDLE so back-to-back jobs lose no cycle
        // beyond the done cycle itself.
        IDLE, DONE: begin
          if (win_vld) begin
            state_q        <= RUN;
            id_q           <= win_id;
            shreg_q        <= word_i[win_id*LEN +: LEN];
            ab_q           <= 2'b00;
            cnt_q          <= '0;
            gnt_q[win_id]  <= 1'b1;
            ptr_q          <= ptr_d;
            busy_q         <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          ab_q    <= ab_d;
          shreg_q <= shreg_q >> 1;
          cnt_q   <= cnt_d;
          if (cnt_d == CW'(LEN)) begin
            final_ab_q <= ab_d;
            done_id_q  <= id_q;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign done_id_o  = done_id_q;
  assign final_ab_o = final_ab_q;

endmodule

// File: tb/tb_moore_rr_scheduler.sv
module tb_moore_rr_scheduler;
  localparam int NREQ = 4;
  localparam int LEN  = 8;
  localparam int IW   = 2;

  logic                clk = 1'b0;
  logic                res;
  logic [NREQ-1:0]     req;
  logic [NREQ*LEN-1:0] word;
  logic [NREQ-1:0]     gnt;
  logic                busy, done;
  logic [IW-1:0]       done_id;
  logic [1:0]          final_ab;

  int checks = 0;
  int failures = 0;

  moore_rr_scheduler #(.NREQ(NREQ), .LEN(LEN)) dut (
    .clk_i(clk), .res_i(res), .req_i(req), .word_i(word),
    .gnt_o(gnt), .busy_o(busy), .done_o(done),
    .done_id_o(done_id), .final_ab_o(final_ab)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int id, input logic [LEN-1:0] w);
    word[id*LEN +: LEN] = w;
  endtask

  function automatic logic [NREQ-1:0] oh(input int id);
    logic [NREQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Engine transition table, as listed for each input bit.
  function automatic logic [1:0] nxt(input logic [1:0] s, input logic x);
    if (!x) begin
      case (s)
        2'b00:   return 2'b01;
        2'b01:   return 2'b11;
        2'b11:   return 2'b00;
        default: return 2'b11;
      endcase
    end
    return (s == 2'b01) ? 2'b00 : s;
  endfunction

  function automatic logic [1:0] fold(input logic [LEN-1:0] w);
    logic [1:0] s;
    s = 2'b00;
    for (int k = 0; k < LEN; k++) s = nxt(s, w[k]);
    return s;
  endfunction

  // Run LEN RUN edges after a grant: no grant, busy high, done only on the last.
  task automatic run_bits(input string tag, input int id, input logic [1:0] fab);
    for (int c = 1; c <= LEN; c++) begin
      tick();
      chk({tag, ".gnt"}, gnt, 0);
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".done"}, done, (c == LEN) ? 1 : 0);
      if (c == LEN) begin
        chk({tag, ".done_id"}, done_id, id);
        chk({tag, ".final_ab"}, final_ab, fab);
      end
    end
  endtask

  // Behavioural model: job progress as an edge count since the grant.
  int              m_ptr = 0, m_t = 0, m_id = 0, m_did = 0;
  bit              m_act = 0, m_done = 0;
  logic [LEN-1:0]  m_word = '0;
  logic [NREQ-1:0] m_gnt = '0;
  logic [1:0]      m_fab = 2'b00;

  task automatic model_step();
    m_gnt  = '0;
    m_done = 0;
    if (res) begin
      m_ptr = 0; m_act = 0; m_t = 0; m_did = 0; m_fab = 2'b00;
    end else if (m_act && m_t < LEN) begin
      m_t++;
      if (m_t == LEN) begin
        m_done = 1;
        m_did  = m_id;
        m_fab  = fold(m_word);
      end
    end else begin
      m_act = 0;
      for (int off = 0; off < NREQ; off++) begin
        if (!m_act && req[(m_ptr + off) % NREQ]) begin
          m_act  = 1;
          m_t    = 0;
          m_id   = (m_ptr + off) % NREQ;
          m_word = word[m_id*LEN +: LEN];
          m_gnt  = oh(m_id);
        end
      end
      if (m_act) m_ptr = (m_id + 1) % NREQ;
    end
  endtask

  typedef struct {
    int             id;
    logic [LEN-1:0] w;
    logic [1:0]     fab;
  } job_t;
  job_t jobs[5];

  initial begin
    jobs[0] = '{2, 8'h00, 2'b11};
    jobs[1] = '{2, 8'hFF, 2'b00};
    jobs[2] = '{2, 8'h01, 2'b01};
    jobs[3] = '{1, 8'h3C, 2'b01};
    jobs[4] = '{3, 8'h80, 2'b00};

    // Reset held with all requests pending.
    res = 1'b1; req = 4'b1111; word = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst.gnt", gnt, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.done_id", done_id, 0);
      chk("rst.final_ab", final_ab, 0);
    end
    res = 1'b0;
    tick();
    chk("rr.first_gnt", gnt, 4'b0001);
    chk("rr.first_busy", busy, 1);
    // Round robin with all requests held: done then gnt on the next edge.
    for (int j = 1; j <= 4; j++) begin
      run_bits("rr", (j - 1) % NREQ, 2'b11);
      tick();
      chk("rr.gnt", gnt, oh(j % NREQ));
      chk("rr.done_clear", done, 0);
      chk("rr.busy", busy, 1);
    end
    res = 1'b1; req = '0;
    tick();
    res = 1'b0;
    tick();

    // Single jobs; word is scrambled after the grant edge.
    foreach (jobs[j]) begin
      req = oh(jobs[j].id);
      set_word(jobs[j].id, jobs[j].w);
      tick();
      chk("job.gnt", gnt, oh(jobs[j].id));
      chk("job.busy", busy, 1);
      req = '0;
      word = $urandom;
      run_bits("job", jobs[j].id, jobs[j].fab);
      tick();
      chk("job.idle_busy", busy, 0);
      chk("job.done_clear", done, 0);
      chk("job.final_hold", final_ab, jobs[j].fab);
    end

    // Skip and wrap: grant 2 leaves ptr=3; req 0011 gives 0 then 1.
    word = '0;
    req = 4'b0100;
    tick();
    chk("skip.gnt2", gnt, 4'b0100);
    req = 4'b0011;
    run_bits("skip.j2", 2, 2'b11);
    tick();
    chk("skip.gnt0", gnt, 4'b0001);
    run_bits("skip.j0", 0, 2'b11);
    tick();
    chk("skip.gnt1", gnt, 4'b0010);
    req = '0;
    run_bits("skip.j1", 1, 2'b11);
    tick();
    chk("skip.idle", busy, 0);

    // Reset on the 4th RUN edge aborts the job; ptr restarts at 0.
    req = 4'b0100;
    tick();
    chk("abort.gnt", gnt, 4'b0100);
    req = '0;
    for (int i = 0; i < 3; i++) tick();
    res = 1'b1; req = 4'b1010;
    set_word(1, 8'h01);
    tick();
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.final_ab", final_ab, 0);
    chk("abort.done_id", done_id, 0);
    chk("abort.gnt", gnt, 0);
    res = 1'b0;
    tick();
    chk("abort.regnt", gnt, 4'b0010);
    req = '0;
    run_bits("abort.j1", 1, 2'b01);
    tick();

    // Withdrawn request: one-cycle req[1] during a run is never served.
    word = '0;
    req = 4'b0001;
    tick();
    chk("wd.gnt", gnt, 4'b0001);
    for (int c = 1; c <= LEN; c++) begin
      req = (c == 3) ? 4'b0010 : 4'b0000;
      tick();
      chk("wd.gnt_run", gnt, 0);
      chk("wd.done", done, (c == LEN) ? 1 : 0);
    end
    req = '0;
    tick();
    chk("wd.idle_busy", busy, 0);
    chk("wd.idle_gnt", gnt, 0);
    tick();
    chk("wd.never", gnt, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      res  = (i == 0) || ($urandom_range(0, 79) == 0);
      req  = NREQ'($urandom);
      word = $urandom;
      model_step();
      tick();
      chk("rnd.gnt", gnt, m_gnt);
      chk("rnd.busy", busy, m_act);
      chk("rnd.done", done, m_done);
      chk("rnd.done_id", done_id, m_did);
      chk("rnd.final_ab", final_ab, m_fab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
